// File: rtl/cmp_seq_if.sv
// Handshake and operand bundle for cmp_seq: start/operands/cascade-in toward the
// comparator, busy/done/cascade-out back from it.
interface cmp_seq_if #(
    parameter int WIDTH = 16
);
    logic             strt;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             AgtBi;
    logic             AeqBi;
    logic             AltBi;
    logic             busy;
    logic             done;
    logic             AgtBo;
    logic             AeqBo;
    logic             AltBo;

    modport master (
        output strt, A, B, AgtBi, AeqBi, AltBi,
        input  busy, done, AgtBo, AeqBo, AltBo
    );

    modport slave (
        input  strt, A, B, AgtBi, AeqBi, AltBi,
        output busy, done, AgtBo, AeqBo, AltBo
    );
endinterface

// File: rtl/cmp_seq.sv
// Sequential MSB-first magnitude comparator with {gt,eq,lt} cascade, BITS_PER_CYC bits per clock.
// Define CMP_EARLY_DONE_EN to finish as soon as the first differing slice decides the result.
module cmp_seq #(
    parameter int WIDTH        = 16,
    parameter int BITS_PER_CYC = 1,
    parameter int SIGNED       = 0
) (
    input logic       clk,
    input logic       rst_n,
    cmp_seq_if.slave  bus
);
    localparam int N     = WIDTH / BITS_PER_CYC;
    localparam int CNT_W = $clog2(N + 1);

    if (WIDTH < 2 || (WIDTH % BITS_PER_CYC) != 0) begin : g_param_check
        $error("cmp_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYC");
    end

    typedef enum logic {IDLE, CMP} state_t;

    state_t                  state;
    logic [WIDTH-1:0]        sh_a;
    logic [WIDTH-1:0]        sh_b;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              casc;
    logic                    dec;
    logic                    dec_gt;
    logic                    running;
    logic                    done_pulse;
    logic [2:0]              result;

    logic [BITS_PER_CYC-1:0] sl_a;
    logic [BITS_PER_CYC-1:0] sl_b;
    logic                    sl_gt;
    logic                    sl_lt;
    logic                    now_dec;
    logic                    now_gt;
    logic                    last;
    logic                    finish;

    always_comb begin
        sl_a = sh_a[WIDTH-1 -: BITS_PER_CYC];
        sl_b = sh_b[WIDTH-1 -: BITS_PER_CYC];
        // Flipping both sign bits turns a two's-complement compare into an unsigned one.
        if (SIGNED != 0 && cnt == CNT_W'(N)) begin
            sl_a[BITS_PER_CYC-1] = ~sl_a[BITS_PER_CYC-1];
            sl_b[BITS_PER_CYC-1] = ~sl_b[BITS_PER_CYC-1];
        end
        sl_gt   = (sl_a > sl_b);
        sl_lt   = (sl_a < sl_b);
        now_dec = dec | sl_gt | sl_lt;
        now_gt  = dec ? dec_gt : sl_gt;
        last    = (cnt == CNT_W'(1));
`ifdef CMP_EARLY_DONE_EN
        finish  = last | now_dec;
`else
        finish  = last;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            done_pulse <= 1'b0;
            result     <= 3'b000;
            sh_a       <= '0;
            sh_b       <= '0;
            cnt        <= '0;
            casc       <= 3'b000;
            dec        <= 1'b0;
            dec_gt     <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.strt) begin
                        sh_a    <= bus.A;
                        sh_b    <= bus.B;
                        casc    <= {bus.AgtBi, bus.AeqBi, bus.AltBi};
                        result  <= 3'b000;
                        cnt     <= CNT_W'(N);
                        dec     <= 1'b0;
                        dec_gt  <= 1'b0;
                        running <= 1'b1;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    sh_a   <= sh_a << BITS_PER_CYC;
                    sh_b   <= sh_b << BITS_PER_CYC;
                    cnt    <= cnt - 1'b1;
                    dec    <= now_dec;
                    dec_gt <= now_gt;
                    if (finish) begin
                        // Equal operands pass the captured cascade through untouched.
                        result     <= now_dec ? {now_gt, 1'b0, ~now_gt} : casc;
                        done_pulse <= 1'b1;
                        running    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = running;
    assign bus.done  = done_pulse;
    assign bus.AgtBo = result[2];
    assign bus.AeqBo = result[1];
    assign bus.AltBo = result[0];
endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
- Parametrised sequential magnitude comparator: successor to the 1-bit cascadable comparator cell.
- Compares two WIDTH-bit operands MSB-first, BITS_PER_CYC bits per clock, using a start/done handshake.
- Preserves the one-hot {gt,eq,lt} cascade in/out convention, so results chain with lower-significance comparators.
- Used in the audio path for peak/threshold detection on sample words where a full-width combinational compare is too costly.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 2.
- BITS_PER_CYC, 1, bits resolved per clock; must divide WIDTH exactly (elaboration $error otherwise).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- strt  in  1  start request; sampled only when busy=0.
- A  in  WIDTH  operand A; captured on accepted strt.
- B  in  WIDTH  operand B; captured on accepted strt.
- AgtBi  in  1  cascade in: lower-significance A>B; captured on strt.
- AeqBi  in  1  cascade in: lower-significance A==B; captured on strt.
- AltBi  in  1  cascade in: lower-significance A<B; captured on strt.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- AgtBo  out  1  result A>B; held until the next accepted strt.
- AeqBo  out  1  result A==B; held until the next accepted strt.
- AltBo  out  1  result A<B; held until the next accepted strt.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0.
  - {AgtBo,AeqBo,AltBo}=3'b000 (no result); internal shift registers and counter cleared.
- Derived constant N = WIDTH/BITS_PER_CYC; counter width $clog2(N+1).
- IDLE:
  - strt=1 captures A, B and the cascade inputs into shadow registers.
  - Clears the result to 3'b000, loads counter=N, goes to CMP.
  - Sets busy=1 on the following cycle.
- CMP, each cycle:
  - Examine the top BITS_PER_CYC bits of the shadow A/B.
  - If still undecided and the slices differ, latch gt/lt from the slice compare.
  - SIGNED=1: the first slice (containing the sign bit) has its MSB comparison inverted; remaining bits compare as unsigned.
  - Shift both shadow registers left by BITS_PER_CYC; decrement the counter.
  - When the counter reaches 0, go to IDLE, pulse done=1 for exactly one cycle, drop busy the same cycle, and drive the result.
- Result rules:
  - A differs from B: one-hot gt or lt per the first differing slice; the cascade inputs are ignored.
  - A==B: outputs = captured cascade inputs verbatim, including non-one-hot patterns (pass-through, no correction).
- Latency: done asserts exactly N cycles after the accepted strt cycle.
- strt while busy=1: ignored, with no effect on the compare in flight. The operands on A/B may change freely after capture.
- strt in the same cycle as done: accepted (IDLE is entered that edge, so strt is sampled on the next edge). Back-to-back throughput is one compare per N+1 cycles.
- Reset mid-compare: aborts immediately to the reset values; no done pulse.

Optional Feature:
- Macro: CMP_EARLY_DONE_EN.
- Defined:
  - When the result is decided in CMP (first differing slice), go to IDLE that cycle and pulse done.
  - Latency becomes k cycles, where k = 1-based index of the first differing slice from the MSB end (k <= N).
  - Equal operands still take N cycles.
- Undefined: fixed latency of N cycles regardless of data. The decided result is held internally until the counter expires.

Test Plan:
- WIDTH=16, BPC=1, unsigned; A=16'h8000, B=16'h7FFF, cascade=3'b010 -> done exactly 16 cycles after strt, {gt,eq,lt}=3'b100, busy high for 16 cycles.
- A=B=16'h1234, cascade swept over 3'b100, 3'b010, 3'b001 -> output equals the cascade input each time; A=B with cascade=3'b000 -> output 3'b000.
- SIGNED=1; A=16'hFFFF (-1), B=16'h0001 -> 3'b001; SIGNED=0, same operands -> 3'b100.
- BPC=4; A=16'h00A0, B=16'h00B0 -> done at 4 cycles, result 3'b001. With CMP_EARLY_DONE_EN: done at 3 cycles.
- strt re-asserted at cycle 5 of a busy compare with different A/B -> the first result is unaffected and no second compare starts; strt coincident with done -> new compare starts and its done lands N+1 cycles later.
- rst_n pulsed low at cycle 7 of a compare -> busy, done and outputs go to 0 asynchronously; no done after release; the next strt completes normally.
